// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
//   state_e : responder FSM states (idle / wait states / response held)
//   strb_t  : one write-enable bit per byte lane of a 32-bit word
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_LSB   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  typedef logic [WORD_BYTES-1:0] strb_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed 32-bit storage with a synchronous byte-strobed write and a
// combinational read of the same address. Contents are not reset.
// Ports:
//   clk_i   : clock, rising edge
//   we_i    : write enable for this edge
//   addr_i  : word index
//   wdata_i : write data
//   wstrb_i : byte-lane enables, bit i covers wdata_i[8i+7:8i]
//   rdata_o : word currently stored at addr_i
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AddrW = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  input  strb_t            wstrb_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wstrb_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for load, store and fetch requests. One request is
// accepted at a time, held for LATENCY wait-state cycles, executed against an
// internal word array on the last wait-state edge, and answered with exactly
// one response that is held until the requester takes it.
// Optional build macro: MEM_RESP_MISALIGN_TRAP_EN -- when defined, accesses
// with addr[1:0] != 0 return an error and never write; when undefined the low
// address bits are ignored and the containing word is accessed.
// Ports:
//   clk, rst                  : clock (rising edge), async active-high reset
//   req_valid / req_ready     : request handshake
//   req_we, req_addr          : 1 = write; byte address
//   req_wdata, req_wstrb      : write data and byte-lane enables
//   rsp_valid / rsp_ready     : response handshake
//   rsp_rdata, rsp_err        : read data (0 for writes/errors); access error
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  strb_t       req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (DEPTH_WORDS < 16 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_depth_chk
    $error("DEPTH_WORDS must be a power of two and at least 16");
  end
  if (LATENCY < 1) begin : g_lat_chk
    $error("LATENCY must be at least 1");
  end
  if (ADDR_BASE[ADDR_LSB-1:0] != '0) begin : g_base_chk
    $error("ADDR_BASE must be word-aligned");
  end

  state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  // Request captured at acceptance; later changes on the request port are ignored.
  logic        req_we_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  strb_t       req_wstrb_q;

  logic [31:0] word_idx;
  logic        in_range;
  logic        access_err;
  logic        commit;
  logic        arr_we;
  logic [31:0] arr_rdata;

  // Offset wraps modulo 2^32, so addresses below ADDR_BASE land far out of range.
  assign word_idx = (req_addr_q - ADDR_BASE) >> ADDR_LSB;
  assign in_range = (word_idx < DEPTH_WORDS);

  always_comb begin
    access_err = !in_range;
`ifdef MEM_RESP_MISALIGN_TRAP_EN
    if (req_addr_q[ADDR_LSB-1:0] != '0) begin
      access_err = 1'b1;
    end
`endif
  end

  // The access executes on the edge that leaves the last wait state.
  assign commit = (state_q == StBusy) && (cnt_q == '0);
  assign arr_we = commit && req_we_q && !access_err;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem_array (
    .clk_i  (clk),
    .we_i   (arr_we),
    .addr_i (word_idx[AddrW-1:0]),
    .wdata_i(req_wdata_q),
    .wstrb_i(req_wstrb_q),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready_q) begin
            req_we_q    <= req_we;
            req_addr_q  <= req_addr;
            req_wdata_q <= req_wdata;
            req_wstrb_q <= req_wstrb;
            cnt_q       <= CntW'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= access_err;
            rsp_rdata_q <= (access_err || req_we_q) ? '0 : arr_rdata;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 3;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_chk = 0;
  int n_err = 0;

  mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .ADDR_BASE  (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Transaction-level reference model ----------------
  // Cycle n is the interval after the n-th rising edge. A request accepted at
  // the edge closing cycle acc executes at the edge closing cycle acc+LAT and
  // its response is visible from cycle acc+LAT+1 until rsp_ready is taken.
  logic [31:0] mmem [DEPTH];
  int          cyc = 0;
  int          acc = 0;
  bit          pending = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  task automatic model_execute();
    logic [31:0] off;
    logic [31:0] idx;
    bit          err;
    off = p_addr - BASE;
    idx = off / 4;
    err = (idx >= DEPTH);
`ifdef MEM_RESP_MISALIGN_TRAP_EN
    if (p_addr % 4 != 0) err = 1'b1;
`endif
    exp_err   = err;
    exp_rdata = '0;
    if (!err && p_we) begin
      for (int b = 0; b < 4; b++)
        if (p_wstrb[b]) mmem[idx][8*b +: 8] = p_wdata[8*b +: 8];
    end else if (!err) begin
      exp_rdata = mmem[idx];
    end
  endtask

  always @(posedge rst) pending = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      pending = 1'b0;
    end else if (pending) begin
      if (cyc == acc + LAT) model_execute();
      else if (cyc >= acc + LAT + 1 && rsp_ready) pending = 1'b0;
    end else if (req_valid) begin
      pending = 1'b1;
      acc     = cyc;
      p_we    = req_we;
      p_addr  = req_addr;
      p_wdata = req_wdata;
      p_wstrb = req_wstrb;
    end
    cyc = cyc + 1;
  end

  // Single compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    bit exp_v;
    exp_v = pending && (cyc >= acc + LAT + 1);
    chk("req_ready", {31'b0, req_ready}, {31'b0, !pending});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
    if (exp_v) begin
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    end
  end

  // ---------------- Directed driver ----------------
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int hold,
                     output logic [31:0] rd, output logic er);
    bit rdy;
    int n;
    int lat;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    n = 0;
    do begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    #1;
    // Scramble the request port: the in-flight access must not notice.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'hBAD0_BAD3;
    req_wdata = ~wdata;
    req_wstrb = ~wstrb;
    chk("accept", {31'b0, rdy}, 32'd1);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, LAT);
    rd = rsp_rdata;
    er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_rdata", rsp_rdata, rd);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    chk("idle_valid", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    rst = 1'b0;

    // Give every word a known value: word i holds A500_00ii.
    for (int i = 0; i < DEPTH; i++) txn(1'b1, BASE + 32'(4 * i), 32'hA500_0000 | 32'(i), 4'hF, 0, rd, er);

    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    chk("wr_full_err", {31'b0, er}, 32'd0);
    chk("wr_full_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
    chk("rd_full", rd, 32'hDEAD_BEEF);
    chk("rd_full_err", {31'b0, er}, 32'd0);

    txn(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, rd, er);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    chk("rd_partial", rd, 32'hDEAD_BEAA);

    txn(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF, 2, rd, er);
    chk("oor_rd_err", {31'b0, er}, 32'd1);
    chk("oor_rd_rdata", rd, 32'd0);
    txn(1'b1, BASE + 32'(4 * DEPTH), 32'h1111_1111, 4'hF, 0, rd, er);
    chk("oor_wr_err", {31'b0, er}, 32'd1);
    txn(1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'hF, 0, rd, er);
    chk("oor_last_word", rd, 32'hA500_000F);
    txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 0, rd, er);
    chk("wrap_err", {31'b0, er}, 32'd1);

    txn(1'b1, 32'h22, 32'h1234_5678, 4'hF, 0, rd, er);
`ifdef MEM_RESP_MISALIGN_TRAP_EN
    chk("mis_wr_err", {31'b0, er}, 32'd1);
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);
    chk("mis_rd_back", rd, 32'hA500_0008);
    txn(1'b0, 32'h21, 32'h0, 4'hF, 0, rd, er);
    chk("mis_rd_err", {31'b0, er}, 32'd1);
`else
    chk("mis_wr_err", {31'b0, er}, 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);
    chk("mis_rd_back", rd, 32'h1234_5678);
    txn(1'b0, 32'h21, 32'h0, 4'hF, 0, rd, er);
    chk("mis_rd_word", rd, 32'h1234_5678);
`endif

    txn(1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
    chk("zstrb_err", {31'b0, er}, 32'd0);
    txn(1'b0, 32'h24, 32'h0, 4'hF, 0, rd, er);
    chk("zstrb_rd", rd, 32'hA500_0009);

    // Reset in the second wait-state cycle of a write: nothing may commit.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'hFFFF_0000;
    req_wstrb = 4'hF;
    @(negedge clk);
    chk("mid_pre_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    txn(1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);
    chk("mid_target", rd, 32'hA500_000C);
    txn(1'b0, 32'h2C, 32'h0, 4'hF, 0, rd, er);
    chk("mid_neighbour", rd, 32'hA500_000B);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    chk("mid_other", rd, 32'hDEAD_BEAA);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
